// File: rtl/acl2_mode_sequencer_if.sv
// ============================================================================
// Module      : acl2_mode_sequencer_if
// Description : Command/ready/data-valid handshake between the ACL2 mode
//               sequencer (master) and the ACL2 custom driver (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acl2_mode_sequencer_if;
    logic i_command_ready;
    logic i_data_valid;
    logic o_cmd_soft_reset;
    logic o_cmd_init_linked;
    logic o_cmd_start_linked;
    logic o_cmd_init_measur;
    logic o_cmd_start_measur;

    modport master (
        input  i_command_ready,
        input  i_data_valid,
        output o_cmd_soft_reset,
        output o_cmd_init_linked,
        output o_cmd_start_linked,
        output o_cmd_init_measur,
        output o_cmd_start_measur
    );

    modport slave (
        output i_command_ready,
        output i_data_valid,
        input  o_cmd_soft_reset,
        input  o_cmd_init_linked,
        input  o_cmd_start_linked,
        input  o_cmd_init_measur,
        input  o_cmd_start_measur
    );
endinterface

`default_nettype wire

// File: rtl/acl2_mode_sequencer.sv
// ============================================================================
// Module      : acl2_mode_sequencer
// Description : Boot / soft-reset / init / start command sequencer for the
//               PMOD ACL2 driver with run-phase watchdog and retry handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acl2_mode_sequencer #(
    parameter int parm_fast_simulation = 0,
    parameter int FCLK                 = 20000000,
    parameter int parm_boot_ms         = 10,
    parameter int parm_watchdog_ms     = 500,
    parameter int parm_ack_cycles      = 4096,
    parameter int parm_max_retries     = 3
) (
    input  wire logic                        i_clk_20mhz,
    input  wire logic                        i_rstn_20mhz,
    input  wire logic                        i_mode_linked,
    acl2_mode_sequencer_if.master            drv,
    output logic                             o_running,
    output logic                             o_mode_linked,
    output logic                             o_fault,
    output logic                             o_failed,
    output logic [1:0]                       o_retry_count,
    output logic [15:0]                      o_sample_count
);

    localparam logic [31:0] BOOT_CYCLES = (parm_fast_simulation != 0) ? 32'd100 :
                                          32'(FCLK / 1000 * parm_boot_ms);
    localparam logic [31:0] WDOG_CYCLES = (parm_fast_simulation != 0) ? 32'd1000 :
                                          32'(FCLK / 1000 * parm_watchdog_ms);
    localparam logic [31:0] ACK_CYCLES  = (parm_fast_simulation != 0) ? 32'd64 :
                                          32'(parm_ack_cycles);

    // One-hot command register; bit order matches the drv assignments below.
    localparam logic [4:0] CMD_SR = 5'b00001;
    localparam logic [4:0] CMD_IL = 5'b00010;
    localparam logic [4:0] CMD_SL = 5'b00100;
    localparam logic [4:0] CMD_IM = 5'b01000;
    localparam logic [4:0] CMD_SM = 5'b10000;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RST   = 3'd1,
        ST_INIT  = 3'd2,
        ST_START = 3'd3,
        ST_ACK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_RUN   = 3'd6,
        ST_FAIL  = 3'd7
    } state_t;

    state_t      state_q;
    state_t      ret_q;
    logic [31:0] timer_q;
    logic [4:0]  cmd_q;
    logic        running_q;
    logic        mode_q;
    logic        fault_q;
    logic        failed_q;
    logic [1:0]  retry_q;
    logic [15:0] samples_q;

    logic        w_mode_change;
    logic        w_fault;
    logic [2:0]  w_retry_inc;

    assign w_mode_change = (state_q == ST_RUN) && (i_mode_linked != mode_q);
    assign w_retry_inc   = {1'b0, retry_q} + 3'd1;

    // Linked mode has no watchdog: its samples are activity driven.
    always_comb begin
        w_fault = 1'b0;
        case (state_q)
            ST_ACK:  w_fault = drv.i_command_ready && (timer_q >= ACK_CYCLES - 32'd1);
            ST_DONE: w_fault = !drv.i_command_ready && (timer_q >= WDOG_CYCLES - 32'd1);
            ST_RUN:  w_fault = !w_mode_change && !mode_q && !drv.i_data_valid &&
                               (timer_q >= WDOG_CYCLES - 32'd1);
            default: w_fault = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q   <= ST_BOOT;
            ret_q     <= ST_BOOT;
            timer_q   <= '0;
            cmd_q     <= '0;
            running_q <= 1'b0;
            mode_q    <= 1'b0;
            fault_q   <= 1'b0;
            failed_q  <= 1'b0;
            retry_q   <= '0;
            samples_q <= '0;
        end else begin
            cmd_q <= '0;
            if (w_fault) begin
                fault_q   <= 1'b1;
                running_q <= 1'b0;
                timer_q   <= '0;
                retry_q   <= (w_retry_inc > 3'd3) ? 2'd3 : w_retry_inc[1:0];
                if ({29'd0, w_retry_inc} > 32'(parm_max_retries)) begin
                    state_q  <= ST_FAIL;
                    failed_q <= 1'b1;
                end else begin
                    state_q <= ST_BOOT;
                end
            end else begin
                case (state_q)
                    ST_BOOT: begin
                        if (timer_q >= BOOT_CYCLES - 32'd1) begin
                            state_q <= ST_RST;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 32'd1;
                        end
                    end
                    ST_RST: begin
                        if (drv.i_command_ready) begin
                            cmd_q   <= CMD_SR;
                            ret_q   <= ST_INIT;
                            state_q <= ST_ACK;
                            timer_q <= '0;
                        end
                    end
                    ST_INIT: begin
                        if (drv.i_command_ready) begin
                            mode_q  <= i_mode_linked;
                            cmd_q   <= i_mode_linked ? CMD_IL : CMD_IM;
                            ret_q   <= ST_START;
                            state_q <= ST_ACK;
                            timer_q <= '0;
                        end
                    end
                    ST_START: begin
                        if (drv.i_command_ready) begin
                            cmd_q   <= mode_q ? CMD_SL : CMD_SM;
                            ret_q   <= ST_RUN;
                            state_q <= ST_ACK;
                            timer_q <= '0;
                        end
                    end
                    ST_ACK: begin
                        if (!drv.i_command_ready) begin
                            timer_q <= '0;
                            // The driver stays busy once started, so no DONE wait.
                            if (ret_q == ST_RUN) begin
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                                samples_q <= '0;
                                fault_q   <= 1'b0;
                                retry_q   <= '0;
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end else begin
                            timer_q <= timer_q + 32'd1;
                        end
                    end
                    ST_DONE: begin
                        if (drv.i_command_ready) begin
                            state_q <= ret_q;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 32'd1;
                        end
                    end
                    ST_RUN: begin
                        if (w_mode_change) begin
                            state_q   <= ST_RST;
                            running_q <= 1'b0;
                            timer_q   <= '0;
                        end else if (drv.i_data_valid) begin
                            timer_q <= '0;
                            if (samples_q != 16'hFFFF) begin
                                samples_q <= samples_q + 16'd1;
                            end
                        end else if (!mode_q) begin
                            timer_q <= timer_q + 32'd1;
                        end
                    end
                    ST_FAIL: begin
                        state_q <= ST_FAIL;
                    end
                    default: begin
                        state_q <= ST_BOOT;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign drv.o_cmd_soft_reset   = cmd_q[0];
    assign drv.o_cmd_init_linked  = cmd_q[1];
    assign drv.o_cmd_start_linked = cmd_q[2];
    assign drv.o_cmd_init_measur  = cmd_q[3];
    assign drv.o_cmd_start_measur = cmd_q[4];

    assign o_running      = running_q;
    assign o_mode_linked  = mode_q;
    assign o_fault        = fault_q;
    assign o_failed       = failed_q;
    assign o_retry_count  = retry_q;
    assign o_sample_count = samples_q;

endmodule

`default_nettype wire

// File: tb/tb_acl2_mode_sequencer.sv
// ============================================================================
// Module      : tb_acl2_mode_sequencer
// Description : Directed/randomised bench for acl2_mode_sequencer with a
//               behavioural driver model and command-sequence scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acl2_mode_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mode = 1'b0;
    logic        running, mode_lk, fault, failed;
    logic [1:0]  retry;
    logic [15:0] samples;
    logic [4:0]  cmds;

    int n_checks = 0;
    int n_err    = 0;
    int viol     = 0;
    int log_q[$];
    bit stuck    = 1'b0;
    int busy     = 0;

    always #5 clk = ~clk;

    acl2_mode_sequencer_if bus ();

    acl2_mode_sequencer #(.parm_fast_simulation(1)) dut (
        .i_clk_20mhz    (clk),
        .i_rstn_20mhz   (rstn),
        .i_mode_linked  (mode),
        .drv            (bus.master),
        .o_running      (running),
        .o_mode_linked  (mode_lk),
        .o_fault        (fault),
        .o_failed       (failed),
        .o_retry_count  (retry),
        .o_sample_count (samples)
    );

    assign cmds = {bus.o_cmd_start_measur, bus.o_cmd_init_measur,
                   bus.o_cmd_start_linked, bus.o_cmd_init_linked,
                   bus.o_cmd_soft_reset};

    // Driver model: busy for a random spell after each command, or stuck ready.
    always @(posedge clk) begin
        if (!rstn) begin
            bus.i_command_ready <= 1'b1;
            busy                <= 0;
        end else if (stuck) begin
            bus.i_command_ready <= 1'b1;
        end else if (cmds != 5'd0) begin
            bus.i_command_ready <= 1'b0;
            busy                <= $urandom_range(3, 15);
        end else if (busy > 1) begin
            busy <= busy - 1;
        end else if (busy == 1) begin
            busy                <= 0;
            bus.i_command_ready <= 1'b1;
        end
    end

    // Command monitor: log codes 1=SR 2=IL 3=SL 4=IM 5=SM, flag rule breaks.
    always @(negedge clk) begin
        if ($countones(cmds) > 1) viol++;
        if ($countones(cmds) == 1) begin
            if (bus.i_command_ready !== 1'b1) viol++;
            for (int i = 0; i < 5; i++) if (cmds[i]) log_q.push_back(i + 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_running(input logic v, input int bound, input string tag);
        int k = 0;
        while (running !== v && k < bound) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, running}, {31'd0, v});
    endtask

    task automatic pulse_dv();
        bus.i_data_valid = 1'b1;
        tick(1);
        bus.i_data_valid = 1'b0;
    endtask

    function automatic int seq_code();
        int c = 0;
        foreach (log_q[i]) c = c * 10 + log_q[i];
        return c;
    endfunction

    // Expected command order for one full bring-up in the given mode.
    function automatic int exp_seq(input logic m);
        return m ? 123 : 145;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    initial begin
        int k, n, exp_s;
        bus.i_data_valid = 1'b0;
        tick(3);
        check("reset_outputs", {5'd0, running, mode_lk, fault, failed, retry, samples, cmds}, 32'd0);

        // Measurement bring-up from boot
        log_q.delete();
        #2 rstn = 1'b1;
        k = 0;
        while (log_q.size() == 0 && k < 300) begin tick(1); k++; end
        check_rng("boot_to_soft_reset", k, 98, 106);
        wait_running(1'b1, 500, "run_measur");
        check("cmd_seq_measur", seq_code(), exp_seq(1'b0));
        check("mode_latched_0", {31'd0, mode_lk}, 32'd0);
        check("samples_zero_entry", {16'd0, samples}, 32'd0);
        n = $urandom_range(3, 8);
        exp_s = 0;
        for (int i = 0; i < n; i++) begin
            pulse_dv();
            exp_s = sat16(exp_s + 1);
            tick($urandom_range(1, 60));
        end
        check("samples_measur", {16'd0, samples}, exp_s);

        // Mode change to linked is a re-sequence, not a fault; coincident dv ignored
        log_q.delete();
        mode = 1'b1;
        pulse_dv();
        check("mode_change_stops_run", {31'd0, running}, 32'd0);
        check("mode_change_no_fault", {31'd0, fault}, 32'd0);
        wait_running(1'b1, 600, "run_linked");
        check("cmd_seq_linked", seq_code(), exp_seq(1'b1));
        check("mode_latched_1", {31'd0, mode_lk}, 32'd1);
        check("samples_cleared_reentry", {16'd0, samples}, 32'd0);

        // Linked mode has no watchdog
        tick(5000);
        check("linked_no_watchdog_fault", {31'd0, fault}, 32'd0);
        check("linked_still_running", {31'd0, running}, 32'd1);
        n = $urandom_range(2, 6);
        exp_s = 0;
        for (int i = 0; i < n; i++) begin
            pulse_dv();
            exp_s++;
            tick($urandom_range(100, 400));
        end
        check("samples_linked", {16'd0, samples}, exp_s);

        // Back to measurement, then let the watchdog expire
        log_q.delete();
        mode = 1'b0;
        wait_running(1'b0, 4, "mode_back_stops_run");
        wait_running(1'b1, 600, "run_measur_again");
        check("cmd_seq_measur_again", seq_code(), exp_seq(1'b0));
        k = 0;
        while (fault !== 1'b1 && k < 1500) begin tick(1); k++; end
        check_rng("watchdog_timeout", k, 995, 1005);
        check("watchdog_retry_1", {30'd0, retry}, 32'd1);
        check("watchdog_stops_run", {31'd0, running}, 32'd0);
        wait_running(1'b1, 800, "resequence_after_watchdog");
        check("fault_cleared_on_run", {31'd0, fault}, 32'd0);
        check("retry_cleared_on_run", {30'd0, retry}, 32'd0);

        // Stuck driver: ack timeouts until retries are exhausted
        stuck = 1'b1;
        log_q.delete();
        mode = 1'b1;
        k = 0;
        while (log_q.size() == 0 && k < 50) begin tick(1); k++; end
        check("stuck_first_soft_reset", log_q.size(), 1);
        k = 0;
        while (fault !== 1'b1 && k < 200) begin tick(1); k++; end
        check_rng("ack_timeout", k, 58, 68);
        check("ack_timeout_retry_1", {30'd0, retry}, 32'd1);
        k = 0;
        while (failed !== 1'b1 && k < 3000) begin tick(1); k++; end
        check("failed_latched", {31'd0, failed}, 32'd1);
        check("failed_retry_sat", {30'd0, retry}, 32'd3);
        check("failed_fault", {31'd0, fault}, 32'd1);
        check("four_soft_resets", seq_code(), 1111);
        log_q.delete();
        tick(400);
        check("no_cmd_after_fail", log_q.size(), 0);
        check("failed_terminal", {31'd0, failed}, 32'd1);

        // Asynchronous reset from the failed state and again mid-handshake
        stuck = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("async_reset_from_fail", {5'd0, running, mode_lk, fault, failed, retry, samples, cmds}, 32'd0);
        tick(2);
        mode = 1'b1;
        log_q.delete();
        rstn = 1'b1;
        k = 0;
        while (bus.o_cmd_soft_reset !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        check("soft_reset_before_abort", {31'd0, bus.o_cmd_soft_reset}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("async_reset_in_ack", {5'd0, running, mode_lk, fault, failed, retry, samples, cmds}, 32'd0);
        @(negedge clk);
        log_q.delete();
        rstn = 1'b1;
        k = 0;
        while (log_q.size() == 0 && k < 300) begin tick(1); k++; end
        check_rng("reboot_to_soft_reset", k, 98, 106);
        wait_running(1'b1, 600, "run_after_reset");
        check("cmd_seq_after_reset", seq_code(), exp_seq(1'b1));

        // Sample counter saturation
        exp_s = 0;
        bus.i_data_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            exp_s = sat16(exp_s + 1);
        end
        #1 bus.i_data_valid = 1'b0;
        check("samples_saturate", {16'd0, samples}, exp_s);
        check("pulse_rules", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
